// File: rtl/div_iter_pkg.sv
// Shared definitions for the iterative divider: funct3 codes, default width, FSM states.
package div_iter_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [2:0] INST_DIV  = 3'b100;
    localparam logic [2:0] INST_DIVU = 3'b101;
    localparam logic [2:0] INST_REM  = 3'b110;
    localparam logic [2:0] INST_REMU = 3'b111;

    typedef enum logic [3:0] {
        ST_IDLE = 4'b0001,
        ST_PREP = 4'b0010,
        ST_CALC = 4'b0100,
        ST_DONE = 4'b1000
    } div_state_e;

    // funct3[2] is ignored, so the codes are matched with that bit forced high.
    function automatic logic is_unsigned(input logic [1:0] op);
        return ({1'b1, op} == INST_DIVU) || ({1'b1, op} == INST_REMU);
    endfunction

    function automatic logic is_rem(input logic [1:0] op);
        return ({1'b1, op} == INST_REM) || ({1'b1, op} == INST_REMU);
    endfunction

endpackage

// File: rtl/div_lzc.sv
// Leading-zero counter; an all-zero input returns XLEN.
module div_lzc
    import div_iter_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [XLEN-1:0]            value,
    output logic [$clog2(XLEN+1)-1:0]  count
);

    localparam int CW = $clog2(XLEN + 1);

    // Higher set bits overwrite lower ones, so the MSB-most one decides.
    always_comb begin
        count = CW'(XLEN);
        for (int i = 0; i < XLEN; i++) begin
            if (value[i]) begin
                count = CW'(XLEN - 1 - i);
            end
        end
    end

endmodule

// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU.
// Define DIV_EARLY_TERM_EN to skip leading-zero iterations of the dividend.
module div_iter
    import div_iter_pkg::*;
#(
    parameter int XLEN       = XLEN_DEFAULT,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [2:0]            op_i,
    input  logic [XLEN-1:0]       dividend_i,
    input  logic [XLEN-1:0]       divisor_i,
    input  logic [REG_ADDR_W-1:0] reg_waddr_i,
    input  logic                  flush_i,
    output logic [XLEN-1:0]       result_o,
    output logic                  ready_o,
    output logic                  busy_o,
    output logic [REG_ADDR_W-1:0] reg_waddr_o
);

    localparam int CW = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0] ONE = XLEN'(1);

    div_state_e state_q, state_d;

    logic            unsigned_q;
    logic            rem_op_q;
    logic            neg_q;
    logic [XLEN-1:0] a_q;
    logic [XLEN-1:0] b_q;
    logic [XLEN-1:0] rem_q;
    logic [CW-1:0]   cnt_q;

    logic            op_unused;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] abs_a;
    logic [XLEN-1:0] abs_b;
    logic            div_zero;
    logic [XLEN:0]   rem_ext;
    logic            step_ge;
    logic [XLEN-1:0] rem_sub;
    logic [XLEN-1:0] rem_next;
    logic [XLEN-1:0] raw_res;
    logic [XLEN-1:0] fin_res;
    logic [XLEN-1:0] prep_dvd;
    logic [CW-1:0]   prep_cnt;

    assign op_unused = op_i[2];

    // a_q holds the dividend, then shifts into the quotient during CALC.
    assign a_neg    = ~unsigned_q & a_q[XLEN-1];
    assign b_neg    = ~unsigned_q & b_q[XLEN-1];
    assign abs_a    = a_neg ? (~a_q + ONE) : a_q;
    assign abs_b    = b_neg ? (~b_q + ONE) : b_q;
    assign div_zero = (b_q == '0);

    assign rem_ext  = {rem_q, a_q[XLEN-1]};
    assign step_ge  = rem_ext >= {1'b0, b_q};
    assign rem_sub  = rem_ext[XLEN-1:0] - b_q;
    assign rem_next = step_ge ? rem_sub : rem_ext[XLEN-1:0];

    assign raw_res  = rem_op_q ? rem_q : a_q;
    assign fin_res  = neg_q ? (~raw_res + ONE) : raw_res;

`ifdef DIV_EARLY_TERM_EN
    logic [CW-1:0] lz;

    div_lzc #(.XLEN(XLEN)) u_lzc (
        .value (abs_a),
        .count (lz)
    );

    assign prep_dvd = abs_a << lz;
    assign prep_cnt = CW'(XLEN) - lz;
`else
    assign prep_dvd = abs_a;
    assign prep_cnt = CW'(XLEN);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i && !flush_i) begin
                    state_d = ST_PREP;
                end
            end
            ST_PREP: begin
                if (flush_i || div_zero) begin
                    state_d = ST_IDLE;
                end else if (prep_cnt == '0) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                if (flush_i) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == CW'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // ready_o defaults low every cycle so it can only ever be a single-cycle strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            result_o    <= '0;
            ready_o     <= 1'b0;
            busy_o      <= 1'b0;
            reg_waddr_o <= '0;
            unsigned_q  <= 1'b0;
            rem_op_q    <= 1'b0;
            neg_q       <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
        end else begin
            ready_o <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_i && !flush_i) begin
                        unsigned_q  <= is_unsigned(op_i[1:0]);
                        rem_op_q    <= is_rem(op_i[1:0]);
                        a_q         <= dividend_i;
                        b_q         <= divisor_i;
                        reg_waddr_o <= reg_waddr_i;
                        busy_o      <= 1'b1;
                    end
                end
                ST_PREP: begin
                    if (flush_i) begin
                        busy_o <= 1'b0;
                    end else if (div_zero) begin
                        result_o <= rem_op_q ? a_q : '1;
                        ready_o  <= 1'b1;
                        busy_o   <= 1'b0;
                    end else begin
                        a_q   <= prep_dvd;
                        b_q   <= abs_b;
                        rem_q <= '0;
                        cnt_q <= prep_cnt;
                        neg_q <= rem_op_q ? a_neg : (a_neg ^ b_neg);
                    end
                end
                ST_CALC: begin
                    if (flush_i) begin
                        busy_o <= 1'b0;
                    end else begin
                        a_q   <= {a_q[XLEN-2:0], step_ge};
                        rem_q <= rem_next;
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                ST_DONE: begin
                    busy_o <= 1'b0;
                    if (!flush_i) begin
                        result_o <= fin_res;
                        ready_o  <= 1'b1;
                    end
                end
                default: busy_o <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter: directed corner cases then randomized ops vs. an arithmetic model.
module tb_div_iter;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic [2:0]  op_i;
    logic [31:0] dividend_i;
    logic [31:0] divisor_i;
    logic [4:0]  reg_waddr_i;
    logic        flush_i;
    logic [31:0] result_o;
    logic        ready_o;
    logic        busy_o;
    logic [4:0]  reg_waddr_o;

    int   vectors = 0;
    int   miscompares = 0;
    int   gotEdge;
    logic gotReady;
    logic busyBad;

    localparam logic [2:0] OP_DIV  = 3'd4;
    localparam logic [2:0] OP_DIVU = 3'd5;
    localparam logic [2:0] OP_REM  = 3'd6;
    localparam logic [2:0] OP_REMU = 3'd7;

    div_iter #(.XLEN(32), .REG_ADDR_W(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .op_i        (op_i),
        .dividend_i  (dividend_i),
        .divisor_i   (divisor_i),
        .reg_waddr_i (reg_waddr_i),
        .flush_i     (flush_i),
        .result_o    (result_o),
        .ready_o     (ready_o),
        .busy_o      (busy_o),
        .reg_waddr_o (reg_waddr_o)
    );

    always #5 clk = ~clk;

    // RISC-V M semantics straight from integer arithmetic; 64-bit math absorbs MIN/-1.
    function automatic logic [31:0] refResult(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        longint sa;
        longint sb;
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        if (op[0]) return op[1] ? (a % b) : (a / b);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        return op[1] ? 32'(sa % sb) : 32'(sa / sb);
    endfunction

    function automatic int refLatency(input logic [2:0] op, input logic [31:0] a,
                                      input logic [31:0] b);
        longint mag;
        int     bits;
        if (b == 32'd0) return 1;
        mag = op[0] ? longint'(a) : longint'($signed(a));
        if (mag < 0) mag = -mag;
        bits = 0;
        while (mag != 0) begin
            bits++;
            mag = mag >> 1;
        end
`ifdef DIV_EARLY_TERM_EN
        return bits + 2;
`else
        return 34;
`endif
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Accept edge is E0; afterwards wait up to 60 edges for ready_o, noting busy_o drops.
    // intrudeAt > 0 re-asserts start_i with other operands after that edge.
    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] waddr, input int intrudeAt);
        @(negedge clk);
        start_i     = 1'b1;
        op_i        = op;
        dividend_i  = a;
        divisor_i   = b;
        reg_waddr_i = waddr;
        @(posedge clk);
        #1;
        start_i  = 1'b0;
        gotReady = 1'b0;
        busyBad  = 1'b0;
        gotEdge  = 0;
        for (int k = 1; k <= 60 && !gotReady; k++) begin
            @(posedge clk);
            #1;
            start_i = 1'b0;
            if (ready_o === 1'b1) begin
                gotReady = 1'b1;
                gotEdge  = k;
            end else if (busy_o !== 1'b1) begin
                busyBad = 1'b1;
            end
            if (k == intrudeAt && !gotReady) begin
                start_i     = 1'b1;
                op_i        = OP_DIVU;
                dividend_i  = 32'd50;
                divisor_i   = 32'd5;
                reg_waddr_i = ~waddr;
            end
        end
        start_i = 1'b0;
    endtask

    task automatic runOp(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] waddr, input int intrudeAt);
        applyStimulus(op, a, b, waddr, intrudeAt);
        checkOutput({tag, " ready"}, 32'(gotReady), 32'd1);
        checkOutput({tag, " latency"}, 32'(gotEdge), 32'(refLatency(op, a, b)));
        checkOutput({tag, " result"}, result_o, refResult(op, a, b));
        checkOutput({tag, " waddr"}, 32'(reg_waddr_o), 32'(waddr));
        checkOutput({tag, " busy at ready"}, 32'(busy_o), 32'd0);
        checkOutput({tag, " busy during op"}, 32'(busyBad), 32'd0);
    endtask

    task automatic checkIdle(input string tag, input logic [31:0] heldResult);
        @(posedge clk);
        #1;
        checkOutput({tag, " strobe end"}, 32'(ready_o), 32'd0);
        checkOutput({tag, " idle busy"}, 32'(busy_o), 32'd0);
        checkOutput({tag, " result held"}, result_o, heldResult);
    endtask

    initial begin
        logic        sawReady;
        logic [2:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [4:0]  rw;
        int          mode;

        rst         = 1'b1;
        start_i     = 1'b1;
        flush_i     = 1'b0;
        op_i        = OP_DIVU;
        dividend_i  = 32'd100;
        divisor_i   = 32'd7;
        reg_waddr_i = 5'd9;

        // Reset wins over a pending start.
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset result", result_o, 32'd0);
        checkOutput("reset ready", 32'(ready_o), 32'd0);
        checkOutput("reset busy", 32'(busy_o), 32'd0);
        checkOutput("reset waddr", 32'(reg_waddr_o), 32'd0);
        start_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        runOp("divu 100/7", OP_DIVU, 32'd100, 32'd7, 5'd11, 0);
        checkIdle("divu 100/7", refResult(OP_DIVU, 32'd100, 32'd7));
        runOp("rem -7/2", OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd1, 0);
        runOp("div -7/2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd2, 0);
        runOp("remu max/16", OP_REMU, 32'hFFFF_FFFF, 32'd16, 5'd3, 0);
        runOp("div min/-1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4, 0);
        runOp("rem min/-1", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd5, 0);
        runOp("divu 5/0", OP_DIVU, 32'd5, 32'd0, 5'd6, 0);
        runOp("rem -5/0", OP_REM, 32'hFFFF_FFFB, 32'd0, 5'd7, 0);
        checkIdle("rem -5/0", refResult(OP_REM, 32'hFFFF_FFFB, 32'd0));
        runOp("divu 3/1", OP_DIVU, 32'd3, 32'd1, 5'd8, 0);
        runOp("divu 0/9", OP_DIVU, 32'd0, 32'd9, 5'd10, 0);
        runOp("divu max/1", OP_DIVU, 32'hFFFF_FFFF, 32'd1, 5'd12, 0);
        checkIdle("divu max/1", refResult(OP_DIVU, 32'hFFFF_FFFF, 32'd1));

        // start together with flush in IDLE is refused.
        @(negedge clk);
        start_i = 1'b1;
        flush_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        flush_i = 1'b0;
        checkOutput("start+flush busy", 32'(busy_o), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("start+flush ready", 32'(ready_o), 32'd0);

        // Flush mid-calculation drops the result.
        @(negedge clk);
        start_i     = 1'b1;
        op_i        = OP_DIV;
        dividend_i  = 32'd1000;
        divisor_i   = 32'd3;
        reg_waddr_i = 5'd13;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        flush_i = 1'b1;
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        checkOutput("flush busy", 32'(busy_o), 32'd0);
        checkOutput("flush ready", 32'(ready_o), 32'd0);
        sawReady = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (ready_o === 1'b1) sawReady = 1'b1;
        end
        checkOutput("flush no ready", 32'(sawReady), 32'd0);
        runOp("divu 9/3 after flush", OP_DIVU, 32'd9, 32'd3, 5'd14, 0);

        // A second start while busy must not disturb the op in flight.
        runOp("start while busy", OP_DIVU, 32'd100, 32'd7, 5'd3, 3);
        checkIdle("start while busy", refResult(OP_DIVU, 32'd100, 32'd7));

        // Reset in the middle of an op.
        @(negedge clk);
        start_i     = 1'b1;
        op_i        = OP_REMU;
        dividend_i  = 32'd12345;
        divisor_i   = 32'd17;
        reg_waddr_i = 5'd21;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("midop reset busy", 32'(busy_o), 32'd0);
        checkOutput("midop reset result", result_o, 32'd0);
        checkOutput("midop reset waddr", 32'(reg_waddr_o), 32'd0);

        for (int n = 0; n < 40; n++) begin
            rop  = 3'(3'd4 + 3'($urandom_range(0, 3)));
            ra   = $urandom;
            mode = $urandom_range(0, 7);
            if (mode == 0) rb = 32'd0;
            else if (mode == 1) rb = 32'hFFFF_FFFF;
            else if (mode == 2) rb = 32'($urandom_range(1, 15));
            else rb = $urandom;
            if ($urandom_range(0, 3) == 0) ra = 32'($urandom_range(0, 1000));
            if ($urandom_range(0, 9) == 0) ra = 32'h8000_0000;
            rw = 5'($urandom_range(0, 31));
            runOp("random", rop, ra, rb, rw, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
